// File: rtl/reg_scoreboard_rf.sv
// Architectural register file with a per-register pending-write scoreboard for decode issue.
// Optional macro RF_WB_BYPASS_EN forwards a same-cycle writeback into a waiting source operand.
module reg_scoreboard_rf #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uop_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rs1_valid,
    input  logic              rs2_valid,
    input  logic              rd_valid,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              source_not_ready,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              issue_valid,
    output logic              sb_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];

    logic                byp1;
    logic                byp2;
    logic                rs1_rdy;
    logic                rs2_rdy;
    logic                waw_full;
    logic                issue;
    logic [XLEN-1:0]     rs1_val;
    logic [XLEN-1:0]     rs2_val;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                busy;

    always_comb begin
        byp1 = 1'b0;
        byp2 = 1'b0;
`ifdef RF_WB_BYPASS_EN
        byp1 = wb_valid && (wb_addr == rs1) && (cnt[rs1] == CNT_ONE);
        byp2 = wb_valid && (wb_addr == rs2) && (cnt[rs2] == CNT_ONE);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        rs1_rdy = !rs1_valid || (rs1 == '0) || (cnt[rs1] == '0) || byp1;
        rs2_rdy = !rs2_valid || (rs2 == '0) || (cnt[rs2] == '0) || byp2;
        // A retiring write to rd frees a slot in the same cycle.
        waw_full = rd_valid && (rd != '0) && (cnt[rd] == CNT_MAX)
                   && !(wb_valid && (wb_addr == rd));
        source_not_ready = uop_valid && (!rs1_rdy || !rs2_rdy || waw_full);
        issue = uop_valid && !source_not_ready;

        if (!rs1_valid || (rs1 == '0))
            rs1_val = '0;
        else if (byp1)
            rs1_val = wb_data;
        else
            rs1_val = regs[rs1];

        if (!rs2_valid || (rs2 == '0))
            rs2_val = '0;
        else if (byp2)
            rs2_val = wb_data;
        else
            rs2_val = regs[rs2];
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_vec[r] = issue && rd_valid && (rd == ADDR_W'(r));
            dec_vec[r] = wb_valid && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
            busy       = busy | (cnt[r] != '0);
        end
    end

    assign sb_busy = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            rs1_data    <= '0;
            rs2_data    <= '0;
            issue_valid <= 1'b0;
        end else begin
            regs[0] <= '0;
            cnt[0]  <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wb_valid && (wb_addr == ADDR_W'(r)))
                    regs[r] <= wb_data;
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_vec[r] && !inc_vec[r])
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
            issue_valid <= issue;
            if (issue) begin
                rs1_data <= rs1_val;
                rs2_data <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_rf.sv
// Self-checking bench for reg_scoreboard_rf: directed scenarios plus random traffic against an
// array-based reference model of the register file and its pending-write counts.
module tb_reg_scoreboard_rf;

    logic        clk = 1'b0;
    logic        reset;
    logic        uop_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_valid, rs2_valid, rd_valid;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        source_not_ready;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid;
    logic        sb_busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // reference model state
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_iv;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;

    reg_scoreboard_rf dut (
        .clk              (clk),
        .reset            (reset),
        .uop_valid        (uop_valid),
        .rs1              (rs1),
        .rs2              (rs2),
        .rd               (rd),
        .rs1_valid        (rs1_valid),
        .rs2_valid        (rs2_valid),
        .rd_valid         (rd_valid),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .source_not_ready (source_not_ready),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .issue_valid      (issue_valid),
        .sb_busy          (sb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit byp_sel(input logic [4:0] a);
        return BYP && wb_valid && (wb_addr == a) && (m_cnt[a] == 1);
    endfunction

    function automatic bit src_rdy(input logic v, input logic [4:0] a);
        return !v || (a == 0) || (m_cnt[a] == 0) || byp_sel(a);
    endfunction

    function automatic logic [31:0] src_val(input logic v, input logic [4:0] a);
        if (!v || a == 0) return 32'h0;
        if (byp_sel(a)) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_snr();
        bit waw;
        waw = rd_valid && (rd != 0) && (m_cnt[rd] == 3) && !(wb_valid && wb_addr == rd);
        return uop_valid && (!src_rdy(rs1_valid, rs1) || !src_rdy(rs2_valid, rs2) || waw);
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 32; r++)
            if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_cnt[r]  = 0;
        end
        m_iv  = 1'b0;
        m_rs1 = 32'h0;
        m_rs2 = 32'h0;
    endtask

    task automatic idle();
        uop_valid = 0; rs1_valid = 0; rs2_valid = 0; rd_valid = 0;
        rs1 = 0; rs2 = 0; rd = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic set_uop(input logic [4:0] a1, input logic v1, input logic [4:0] a2,
                           input logic v2, input logic [4:0] ad, input logic vd);
        uop_valid = 1; rs1 = a1; rs1_valid = v1; rs2 = a2; rs2_valid = v2; rd = ad; rd_valid = vd;
    endtask

    task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1; wb_addr = a; wb_data = d;
    endtask

    // One clock of traffic: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        bit          snr, iss;
        logic [31:0] v1, v2;
        #1;
        snr = m_snr();
        chk("snr", {31'b0, source_not_ready}, {31'b0, snr});
        chk("sb_busy", {31'b0, sb_busy}, {31'b0, m_busy()});
        iss = uop_valid && !snr;
        v1  = src_val(rs1_valid, rs1);
        v2  = src_val(rs2_valid, rs2);
        @(posedge clk);
        for (int r = 1; r < 32; r++) begin
            bit inc, dec;
            inc = iss && rd_valid && (rd == r);
            dec = wb_valid && (wb_addr == r) && (m_cnt[r] != 0);
            m_cnt[r] = m_cnt[r] + int'(inc) - int'(dec);
        end
        if (wb_valid && wb_addr != 0) m_regs[wb_addr] = wb_data;
        m_iv = iss;
        if (iss) begin
            m_rs1 = v1;
            m_rs2 = v2;
        end
        #1;
        chk("issue_valid", {31'b0, issue_valid}, {31'b0, m_iv});
        chk("rs1_data", rs1_data, m_rs1);
        chk("rs2_data", rs2_data, m_rs2);
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        #2;
        do_reset();
        chk("rst_issue_valid", {31'b0, issue_valid}, 32'h0);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_busy", {31'b0, sb_busy}, 32'h0);

        // plain read
        set_wb(3, 32'hDEADBEEF); step(); idle();
        set_uop(3, 1, 0, 1, 0, 0); step(); idle();
        chk("t2_iv", {31'b0, issue_valid}, 32'h1);
        chk("t2_rs1", rs1_data, 32'hDEADBEEF);
        chk("t2_rs2", rs2_data, 32'h0);

        // RAW on x7
        do_reset();
        set_uop(0, 0, 0, 0, 7, 1); step(); idle();
        set_uop(7, 1, 0, 0, 0, 0); step();
        chk("t3_stall", {31'b0, source_not_ready}, 32'h1);
        step();
        set_wb(7, 32'h55);
        #1 chk("t3_wb_cycle_snr", {31'b0, source_not_ready}, {31'b0, !BYP});
        step();
        wb_valid = 0;
        if (!BYP) begin
            #1 chk("t3_late_snr", {31'b0, source_not_ready}, 32'h0);
            step();
        end
        idle();
        chk("t3_rs1", rs1_data, 32'h55);
        chk("t3_iv", {31'b0, issue_valid}, 32'h1);

        // WAW limit on x9
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_uop(0, 0, 0, 0, 9, 1); step();
        end
        #1 chk("t4_waw_stall", {31'b0, source_not_ready}, 32'h1);
        step();
        set_wb(9, 32'h99);
        #1 chk("t4_waw_release", {31'b0, source_not_ready}, 32'h0);
        step(); idle(); step();

        // simultaneous inc/dec on x4
        do_reset();
        set_uop(0, 0, 0, 0, 4, 1); step();
        set_wb(4, 32'h44); step(); idle();
        #1 chk("t5_busy", {31'b0, sb_busy}, 32'h1);
        set_uop(4, 1, 0, 0, 0, 0); step();
        chk("t5_still_pending", {31'b0, issue_valid}, 32'h0);
        idle(); set_wb(4, 32'h45); step(); idle();
        #1 chk("t5_drained", {31'b0, sb_busy}, 32'h0);

        // x0 behaviour
        set_uop(0, 0, 0, 0, 0, 1); set_wb(0, 32'h1234); step(); idle();
        set_uop(0, 1, 0, 1, 0, 0); step(); idle();
        chk("t6_x0", rs1_data, 32'h0);
        chk("t6_busy", {31'b0, sb_busy}, 32'h0);

        // random traffic on a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                set_uop(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0)
                set_wb(5'($urandom_range(0, 7)), $urandom);
            step();
        end

        // reset mid-traffic, then x5 reads back zero
        set_wb(5, 32'hA5A5A5A5); step();
        set_uop(5, 1, 0, 0, 5, 1);
        reset = 0;
        #1;
        model_reset();
        chk("mid_rst_iv", {31'b0, issue_valid}, 32'h0);
        chk("mid_rst_rs1", rs1_data, 32'h0);
        chk("mid_rst_rs2", rs2_data, 32'h0);
        chk("mid_rst_busy", {31'b0, sb_busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1;
        idle();
        set_uop(5, 1, 0, 0, 0, 0); step(); idle();
        chk("post_rst_x5", rs1_data, 32'h0);
        chk("post_rst_iv", {31'b0, issue_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
